parking_ticket_uart: RTL and testbench
======================================

PARKING_TICKET_UART -- requirements
Module: parking_ticket_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Port clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port ticket_req  input  1  ticket request level from the sensor/ESP stage; synchronous to clk.
REQ-005 Port slot_id  input  4  parking slot number; sampled at request acceptance.
REQ-006 Port fee  input  8  fee code; sampled at request acceptance.
REQ-007 Port tx  output  1  UART line to ESP8266 RX; 8N1, LSB first, idle high.
REQ-008 Port busy  output  1  high while a message is being transmitted.
REQ-009 Port done  output  1  one-cycle pulse when the final byte's stop bit completes.

Function
REQ-010 The block SHALL register ticket_req and treat a 0->1 transition as a request; a level held high SHALL NOT retrigger.
REQ-011 A request seen in cycle N while idle SHALL be accepted: slot_id/fee latched, busy=1 and tx=0 (start bit) from cycle N+1.
REQ-012 Message SHALL be 12 bytes: 'T','K','T',' ','S',hex(slot_id),' ','F',hex(fee[7:4]),hex(fee[3:0]),CR(0x0D),LF(0x0A).
REQ-013 hex() SHALL map 0-9 to 0x30-0x39 and A-F to 0x41-0x46 (upper case).
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT cycles; frame = start(0), 8 data bits LSB first, stop(1).
REQ-015 Bytes SHALL be back-to-back: next start bit directly follows previous stop bit; one message = 12*10*CLKS_PER_BIT cycles.
REQ-016 Byte FSM states: IDLE, START, DATA, STOP; message FSM tracks byte index 0..11, wrapping to IDLE after index 11.
REQ-017 In the cycle the last stop bit ends, done SHALL pulse high for one cycle and busy SHALL fall in that same cycle.
REQ-018 Rising edges of ticket_req while busy SHALL be dropped (unless TKT_PENDING_EN, see REQ-024).
REQ-019 A rising edge coinciding with the done cycle SHALL be treated as arriving while busy.
REQ-020 Changes on slot_id/fee after acceptance SHALL NOT alter the message in flight.

Reset
REQ-021 On reset assertion, immediately and asynchronously: tx=1, busy=0, done=0, FSMs to IDLE, byte index 0, pending flag cleared.
REQ-022 Reset mid-message SHALL abort it with no partial completion; no done pulse is generated.
REQ-023 After reset release, the registered ticket_req SHALL start at 0, so a request already high at release counts as one rising edge.

Configuration
REQ-024 Macro TKT_PENDING_EN defined: a one-deep pending buffer SHALL store one request (slot_id, fee) arriving while busy. Its transmission SHALL start the cycle after done. Further requests while the buffer is full SHALL be dropped.
REQ-025 Macro TKT_PENDING_EN undefined: no pending storage; behaviour is exactly REQ-018.

Structure
REQ-026 Package parking_pkg SHALL hold MSG_LEN=12, the ASCII constants, the byte-FSM state typedef and the hex-to-ASCII function.
REQ-027 Serialisation SHALL reside in sub-module uart_tx_byte (start/8 data/stop, byte-valid in, ready out). Message sequencing and the pending buffer stay in the top.

Verification (CLKS_PER_BIT=4)
REQ-028 Bench SHALL cover reset, then a ticket_req pulse with slot_id=3, fee=0x2A -> tx carries "TKT S3 F2A\r\n"; busy is high for 480 cycles; done pulses once.
REQ-029 Bench SHALL cover request accepted in cycle N -> tx=0 at N+1; each bit exactly 4 cycles; first byte 0x54 LSB first.
REQ-030 Bench SHALL cover ticket_req held high for 2000 cycles -> exactly one message is sent.
REQ-031 Bench SHALL cover a second rising edge at byte 5 with the macro off -> it is dropped. With TKT_PENDING_EN -> a second message with the new slot/fee starts 1 cycle after the first done.
REQ-032 Bench SHALL cover reset asserted mid-byte 7 -> tx=1 and busy=0 immediately, no done pulse, and the next request sends a full 12-byte message.
REQ-033 Bench SHALL cover slot_id=0xF, fee=0x09 -> bytes 'F','0','9' appear in positions 5, 8 and 9.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared constants, byte-FSM state type and message helpers for the parking ticket UART.
package parking_pkg;

  localparam int MSG_LEN = 12;

  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;

  // Upper-case hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Byte at position idx of "TKT S<slot> F<fee_hi><fee_lo>\r\n".
  function automatic logic [7:0] msg_byte(input logic [3:0] idx,
                                          input logic [3:0] slot,
                                          input logic [7:0] fee_code);
    logic [7:0] b;
    b = ASCII_SP;
    case (idx)
      4'd0:    b = ASCII_T;
      4'd1:    b = ASCII_K;
      4'd2:    b = ASCII_T;
      4'd3:    b = ASCII_SP;
      4'd4:    b = ASCII_S;
      4'd5:    b = hex_ascii(slot);
      4'd6:    b = ASCII_SP;
      4'd7:    b = ASCII_F;
      4'd8:    b = hex_ascii(fee_code[7:4]);
      4'd9:    b = hex_ascii(fee_code[3:0]);
      4'd10:   b = ASCII_CR;
      4'd11:   b = ASCII_LF;
      default: b = ASCII_SP;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; a byte offered in the last stop cycle starts with no idle gap.
module uart_tx_byte
  import parking_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       ready,
  output logic       tx,
  output logic       stop_done
);

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

  byte_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_q, tx_n;
  logic        last_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx_q;
    ready     = 1'b0;
    stop_done = 1'b0;
    last_tick = (cnt == LAST_TICK);
    case (state)
      IDLE: begin
        ready = 1'b1;
        cnt_n = '0;
        if (byte_valid) begin
          state_n = START;
          shift_n = byte_data;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (last_tick) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
          tx_n      = shift[0];
        end
      end
      DATA: begin
        if (last_tick) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        if (last_tick) begin
          ready     = 1'b1;
          stop_done = 1'b1;
          cnt_n     = '0;
          // Chain straight into the next start bit when the sequencer has a byte ready.
          if (byte_valid) begin
            state_n = START;
            shift_n = byte_data;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: rtl/parking_ticket_uart.sv
// Sends "TKT S<slot> F<fee>\r\n" over UART on each ticket_req rising edge.
// Define TKT_PENDING_EN to buffer one request that arrives while a message is in flight.
module parking_ticket_uart
  import parking_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ticket_req,
  input  logic [3:0] slot_id,
  input  logic [7:0] fee,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  logic       req_q, busy_q, done_q;
  logic [3:0] byte_idx, slot_q;
  logic [7:0] fee_q;
  logic       tx_ready, stop_done, byte_valid;
  logic [7:0] byte_data;
  logic       rise, accept_new, launch_pend, start_msg, advance, last_end;
  logic [3:0] start_slot;
  logic [7:0] start_fee;
  logic       pend_valid;
  logic [3:0] pend_slot;
  logic [7:0] pend_fee;

  assign rise        = ticket_req & ~req_q;
  assign launch_pend = ~busy_q & pend_valid & tx_ready;
  // The done cycle still counts as busy, so a fresh edge there is never started directly.
  assign accept_new  = ~busy_q & ~done_q & ~pend_valid & rise & tx_ready;
  assign start_msg   = launch_pend | accept_new;
  assign start_slot  = launch_pend ? pend_slot : slot_id;
  assign start_fee   = launch_pend ? pend_fee  : fee;
  assign advance     = busy_q & stop_done & (byte_idx != LAST_IDX);
  assign last_end    = busy_q & stop_done & (byte_idx == LAST_IDX);
  assign byte_valid  = start_msg | advance;
  assign byte_data   = start_msg ? msg_byte(4'd0, start_slot, start_fee)
                                 : msg_byte(byte_idx + 4'd1, slot_q, fee_q);

`ifdef TKT_PENDING_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_slot  <= '0;
      pend_fee   <= '0;
    end else if (launch_pend) begin
      pend_valid <= 1'b0;
    end else if (rise && (busy_q || done_q) && !pend_valid) begin
      pend_valid <= 1'b1;
      pend_slot  <= slot_id;
      pend_fee   <= fee;
    end
  end
`else
  assign pend_valid = 1'b0;
  assign pend_slot  = '0;
  assign pend_fee   = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      byte_idx <= '0;
      slot_q   <= '0;
      fee_q    <= '0;
    end else begin
      req_q  <= ticket_req;
      done_q <= last_end;
      if (start_msg) begin
        busy_q   <= 1'b1;
        byte_idx <= '0;
        slot_q   <= start_slot;
        fee_q    <= start_fee;
      end else if (last_end) begin
        busy_q   <= 1'b0;
        byte_idx <= '0;
      end else if (advance) begin
        byte_idx <= byte_idx + 4'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .ready     (tx_ready),
    .tx        (tx),
    .stop_done (stop_done)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_parking_ticket_uart.sv
// Directed bench for parking_ticket_uart at CLKS_PER_BIT=4 (honours TKT_PENDING_EN if defined).
module tb_parking_ticket_uart;

  logic       clk = 1'b0;
  logic       reset;
  logic       ticket_req;
  logic [3:0] slot_id;
  logic [7:0] fee;
  logic       tx, busy, done;

  int cmp_count  = 0;
  int fail_count = 0;

  logic [7:0] rx_bytes [12];
  int rx_busy, rx_done, rx_glitch, rx_frame;

  always #5 clk = ~clk;

  parking_ticket_uart #(.CLKS_PER_BIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ticket_req(ticket_req),
    .slot_id   (slot_id),
    .fee       (fee),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    cmp_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Raise ticket_req with new slot/fee at a falling edge; the DUT sees it on the next rising edge.
  task automatic applyStimulus(input logic [3:0] s, input logic [7:0] f);
    slot_id    = s;
    fee        = f;
    ticket_req = 1'b1;
  endtask

  // Called at the falling edge of the first start-bit cycle; records 480 cycles of line activity.
  task automatic receiveMessage(input int inj_cycle, input logic [3:0] inj_slot,
                                input logic [7:0] inj_fee, input int abort_cycle);
    logic bit_val;
    int k, b, ph;
    bit_val = 1'b1;
    rx_busy = 0; rx_done = 0; rx_glitch = 0; rx_frame = 0;
    for (int i = 0; i < 12; i++) rx_bytes[i] = 8'h00;
    for (int c = 0; c < 480; c++) begin
      if (c == abort_cycle) return;
      if (inj_cycle >= 0 && c == inj_cycle) applyStimulus(inj_slot, inj_fee);
      if (inj_cycle >= 0 && c == inj_cycle + 1) ticket_req = 1'b0;
      k  = c / 40;
      b  = (c % 40) / 4;
      ph = c % 4;
      if (ph == 0) begin
        bit_val = tx;
        if (b == 0 && tx !== 1'b0) rx_frame++;
        if (b == 9 && tx !== 1'b1) rx_frame++;
        if (b >= 1 && b <= 8) rx_bytes[k][b-1] = tx;
      end else if (tx !== bit_val) begin
        rx_glitch++;
      end
      if (busy === 1'b1) rx_busy++;
      if (done === 1'b1) rx_done++;
      @(negedge clk);
    end
  endtask

  task automatic checkMessage(input string name, input string exp_msg);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("%s_byte%0d", name, i), {24'h0, rx_bytes[i]}, {24'h0, exp_msg[i]});
    checkOutput({name, "_bit_width"}, rx_glitch, 0);
    checkOutput({name, "_framing"},   rx_frame, 0);
    checkOutput({name, "_busy_cycles"}, rx_busy, 480);
    checkOutput({name, "_early_done"}, rx_done, 0);
  endtask

  // At the done cycle: done high, busy low, line idle.
  task automatic checkDone(input string name);
    checkOutput({name, "_done"}, {31'h0, done}, 1);
    checkOutput({name, "_busy_off"}, {31'h0, busy}, 0);
    checkOutput({name, "_tx_idle"}, {31'h0, tx}, 1);
  endtask

  task automatic checkQuiet(input string name, input int cycles);
    int activity;
    activity = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) activity++;
      @(negedge clk);
    end
    checkOutput({name, "_quiet"}, activity, 0);
  endtask

  initial begin
    int resets_done;
    reset = 1'b1; ticket_req = 1'b0; slot_id = 4'h0; fee = 8'h00;
    #1;
    checkOutput("reset_tx", {31'h0, tx}, 1);
    checkOutput("reset_busy", {31'h0, busy}, 0);
    checkOutput("reset_done", {31'h0, done}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single-cycle pulse, slot 3 fee 0x2A.
    applyStimulus(4'h3, 8'h2A);
    checkOutput("pre_accept_tx", {31'h0, tx}, 1);
    @(negedge clk);
    ticket_req = 1'b0;
    checkOutput("accept_tx_start", {31'h0, tx}, 0);
    checkOutput("accept_busy", {31'h0, busy}, 1);
    receiveMessage(-1, 4'h0, 8'h00, -1);
    checkMessage("msg1", "TKT S3 F2A\015\012");
    checkOutput("msg1_first_byte", {24'h0, rx_bytes[0]}, 32'h54);
    checkDone("msg1");
    @(negedge clk);
    checkOutput("msg1_done_single", {31'h0, done}, 0);
    checkQuiet("gap1", 10);

    // Level held for 2000 cycles: exactly one message.
    applyStimulus(4'h1, 8'h10);
    @(negedge clk);
    receiveMessage(-1, 4'h0, 8'h00, -1);
    checkMessage("hold", "TKT S1 F10\015\012");
    checkDone("hold");
    @(negedge clk);
    checkQuiet("hold_tail", 2000 - 482);
    ticket_req = 1'b0;
    checkQuiet("gap2", 10);

    // Second edge during byte 5 with different slot/fee.
    applyStimulus(4'h2, 8'h55);
    @(negedge clk);
    ticket_req = 1'b0;
    receiveMessage(200, 4'h7, 8'h77, -1);
    checkMessage("first", "TKT S2 F55\015\012");
    checkDone("first");
    @(negedge clk);
`ifdef TKT_PENDING_EN
    checkOutput("pend_start_tx", {31'h0, tx}, 0);
    checkOutput("pend_start_busy", {31'h0, busy}, 1);
    receiveMessage(-1, 4'h0, 8'h00, -1);
    checkMessage("pend", "TKT S7 F77\015\012");
    checkDone("pend");
    @(negedge clk);
`endif
    checkQuiet("dropped", 40);

    // Reset in the middle of byte 7, request already high at release.
    applyStimulus(4'h4, 8'h44);
    @(negedge clk);
    ticket_req = 1'b0;
    receiveMessage(-1, 4'h0, 8'h00, 290);
    reset = 1'b1;
    #1;
    checkOutput("abort_tx", {31'h0, tx}, 1);
    checkOutput("abort_busy", {31'h0, busy}, 0);
    applyStimulus(4'hF, 8'h09);
    resets_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1) resets_done++;
    end
    checkOutput("abort_no_done", resets_done, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("release_edge_tx", {31'h0, tx}, 0);
    checkOutput("release_edge_busy", {31'h0, busy}, 1);
    ticket_req = 1'b0;
    receiveMessage(-1, 4'h0, 8'h00, -1);
    checkMessage("after_reset", "TKT SF F09\015\012");
    checkOutput("pos5_F", {24'h0, rx_bytes[5]}, 32'h46);
    checkOutput("pos8_0", {24'h0, rx_bytes[8]}, 32'h30);
    checkOutput("pos9_9", {24'h0, rx_bytes[9]}, 32'h39);
    checkDone("after_reset");
    @(negedge clk);
    checkQuiet("final", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule
